// File: rtl/sram_test_pkg.sv
// Shared constants for the SRAM self-test sequencer: controller op codes,
// one-hot pattern codes and bytes, the NOP command word and FSM states.
package sram_test_pkg;

    localparam int TMR_W = 12;

    localparam logic [1:0] OP_WR_ALL = 2'b11;
    localparam logic [1:0] OP_RD_ALL = 2'b10;
    localparam logic [1:0] OP_WR_ONE = 2'b01;
    localparam logic [1:0] OP_RD_ONE = 2'b00;

    localparam logic [3:0] PAT_00 = 4'b0001;
    localparam logic [3:0] PAT_FF = 4'b0010;
    localparam logic [3:0] PAT_5A = 4'b0100;
    localparam logic [3:0] PAT_A5 = 4'b1000;

    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] BYTE_5A = 8'h5A;
    localparam logic [7:0] BYTE_A5 = 8'hA5;

    // Write-all with an empty pattern: controller returns to IDLE untouched
    localparam logic [31:0] CMD_NOP = 32'hC000_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Steps come in write/read pairs, one pair per pattern
    function automatic logic [3:0] step_pat(input logic [2:0] step);
        logic [3:0] pat;
        pat = PAT_00;
        case (step[2:1])
            2'd0: pat = PAT_00;
            2'd1: pat = PAT_FF;
            2'd2: pat = PAT_5A;
            2'd3: pat = PAT_A5;
            default: pat = PAT_00;
        endcase
        return pat;
    endfunction

    function automatic logic [7:0] pat_byte(input logic [3:0] pat);
        logic [7:0] b;
        b = BYTE_00;
        unique case (1'b1)
            pat[0]: b = BYTE_00;
            pat[1]: b = BYTE_FF;
            pat[2]: b = BYTE_5A;
            pat[3]: b = BYTE_A5;
            default: b = BYTE_00;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] step_cmd(input logic [2:0] step);
        logic [1:0] op;
        op = step[0] ? OP_RD_ALL : OP_WR_ALL;
        return {op, 2'b00, step_pat(step), 8'h00, 16'h0000};
    endfunction

endpackage

// File: rtl/sram_cmd_seq_rd_checker.sv
// Read-back checker: strobes every other cycle of a read step, compares
// against the expected byte, counts mismatches and latches the first one.
module sram_rd_checker
    import sram_test_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int ERR_W        = 16,
    parameter int RD_START_DLY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              step_start,
    input  logic              rd_en,
    input  logic [TMR_W-1:0]  timer,
    input  logic [7:0]        exp_byte,
    input  logic [7:0]        rd_data,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [TMR_W-1:0] DLY = TMR_W'(RD_START_DLY);

    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  rel;
    logic              strobe;

    always_comb begin
        rel    = timer - DLY;
        // Top index bit set means the whole array has been sampled
        strobe = rd_en && (timer >= DLY) && !rel[0] && !idx_q[ADDR_W];
        idx_d  = idx_q;
        err_d  = err_q;
        fail_d = fail_q;
        if (clr) begin
            err_d  = '0;
            fail_d = '0;
        end
        if (step_start) begin
            idx_d = '0;
        end else if (strobe) begin
            idx_d = idx_q + (ADDR_W+1)'(1);
            if (rd_data != exp_byte) begin
                // A zero count means no mismatch yet in this program
                if (err_q == '0) fail_d = idx_q[ADDR_W-1:0];
                if (err_q != '1) err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            idx_q  <= idx_d;
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    assign err_cnt   = err_q;
    assign fail_addr = fail_q;

endmodule

// File: rtl/sram_cmd_seq.sv
// March-style BIST sequencer in front of the SRAM controller.
// Ports: clk, reset (sync, high), start pulse; cmd word to the controller;
// outp_data/half from the controller; busy, done, pass, err_cnt, fail_addr.
// Optional: define SEQ_HALF_CHECK_EN to flag steps that never saw half.
module sram_cmd_seq
    import sram_test_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int ALL_OP_CYCLES = 2056,
    parameter int GAP_CYCLES    = 4,
    parameter int RD_START_DLY  = 5,
    parameter int ERR_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [31:0]       cmd,
    input  logic [7:0]        outp_data,
    input  logic              half,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [TMR_W-1:0] OP_LAST  = TMR_W'(ALL_OP_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             start_acc;
    logic             step_start;
    logic             issue_end;
    logic             proto_ok;

    assign issue_end = (state_q == S_ISSUE) && (timer_q == OP_LAST);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        timer_d   = timer_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        start_acc = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_ISSUE;
                    step_d    = '0;
                    timer_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    start_acc = 1'b1;
                end
            end
            S_ISSUE: begin
                if (issue_end) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (step_q == 3'd7) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // No sampling in the gap, so err_cnt is final here
                        pass_d  = (err_cnt == '0) && proto_ok;
                    end else begin
                        state_d = S_ISSUE;
                        step_d  = step_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        step_start = (state_d == S_ISSUE) && (state_q != S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        cmd = CMD_NOP;
        if (state_q == S_ISSUE) cmd = step_cmd(step_q);
    end

`ifdef SEQ_HALF_CHECK_EN
    logic half_seen_q, half_seen_d;
    logic proto_err_q, proto_err_d;

    always_comb begin
        half_seen_d = half_seen_q;
        proto_err_d = proto_err_q;
        if (start_acc) proto_err_d = 1'b0;
        if (step_start) begin
            half_seen_d = 1'b0;
        end else if (state_q == S_ISSUE) begin
            half_seen_d = half_seen_q | half;
            if (issue_end && !(half_seen_q | half)) proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_seen_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            half_seen_q <= half_seen_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_ok = !proto_err_q;
`else
    logic unused_half;
    assign unused_half = half;
    assign proto_ok    = 1'b1;
`endif

    sram_rd_checker #(
        .ADDR_W      (ADDR_W),
        .ERR_W       (ERR_W),
        .RD_START_DLY(RD_START_DLY)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_acc),
        .step_start(step_start),
        .rd_en     ((state_q == S_ISSUE) && step_q[0]),
        .timer     (timer_q),
        .exp_byte  (pat_byte(step_pat(step_q))),
        .rd_data   (outp_data),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_sram_cmd_seq.sv
// Directed bench for sram_cmd_seq with a behavioural controller and
// a 1Kx8 SRAM model that can inject a stuck bit or a forced-zero read.
module tb_sram_cmd_seq;

    localparam int STEP  = 2060;
    localparam int TOTAL = 8 * STEP;

`ifdef SEQ_HALF_CHECK_EN
    localparam logic EXP_HALF0_PASS = 1'b0;
`else
    localparam logic EXP_HALF0_PASS = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] cmd;
    logic [7:0]  outp_data;
    logic        half;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [9:0]  fail_addr;

    int errors = 0;
    int checks = 0;

    bit stuck_en  = 1'b0;
    bit force0_en = 1'b0;
    bit half_tie0 = 1'b0;

    logic [7:0] mem [1024];
    int ctl_cnt = 0;

    always #5 clk = ~clk;

    sram_cmd_seq dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .outp_data(outp_data), .half(half), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    function automatic logic [7:0] pbyte(input logic [3:0] p);
        case (p)
            4'b0001: return 8'h00;
            4'b0010: return 8'hFF;
            4'b0100: return 8'h5A;
            4'b1000: return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    // Controller: write sweep stores one byte per 2 cycles; read sweep
    // returns address a during cycles 5+2a and 6+2a of the command.
    always @(negedge clk) begin
        int a;
        logic [7:0] d;
        if (reset === 1'b1 || cmd[27:24] == 4'b0000) begin
            ctl_cnt   = 0;
            outp_data = 8'h00;
            half      = 1'b0;
        end else begin
            if (cmd[31:30] == 2'b11) begin
                a = ctl_cnt / 2;
                if (a < 1024) mem[a] = pbyte(cmd[27:24]);
                outp_data = 8'h00;
            end else begin
                a = (ctl_cnt >= 5) ? (ctl_cnt - 5) / 2 : -1;
                d = (a >= 0 && a < 1024) ? mem[a] : 8'h00;
                if (stuck_en && a == 'h123) d[7] = 1'b0;
                if (force0_en && cmd[27:24] == 4'b0010) d = 8'h00;
                outp_data = d;
            end
            half = !half_tie0 && a >= 512 && a < 1024;
            ctl_cnt++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cmd !== 32'hC000_0000) begin errors++; $display("FAIL rst_cmd got=%h want=C0000000", cmd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass got=%b want=0", pass); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err got=%0d want=0", err_cnt); end
        checks++; if (fail_addr !== 10'd0) begin errors++; $display("FAIL rst_faddr got=%h want=0", fail_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_busy_start();
        int t;
        pulse_start();
        checks++; if (cmd !== 32'hC100_0000) begin errors++; $display("FAIL a_w00 got=%h want=C1000000", cmd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a_busy got=%b want=1", busy); end
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
            start = (t == STEP + 100 || t == 6 * STEP + 100);
            if (t == 2056) begin
                checks++; if (cmd !== 32'hC000_0000) begin errors++; $display("FAIL a_gap got=%h want=C0000000", cmd); end
            end
            if (t == STEP) begin
                checks++; if (cmd !== 32'h8100_0000) begin errors++; $display("FAIL a_r00 got=%h want=81000000", cmd); end
            end
            if (t == STEP + 101) begin
                checks++; if (cmd !== 32'h8100_0000) begin errors++; $display("FAIL a_ign1 got=%h want=81000000", cmd); end
            end
            if (t == 6 * STEP + 101) begin
                checks++; if (cmd !== 32'hC800_0000) begin errors++; $display("FAIL a_ign6 got=%h want=C8000000", cmd); end
            end
        end
        start = 1'b0;
        checks++; if (t !== TOTAL) begin errors++; $display("FAIL a_len got=%0d want=%0d", t, TOTAL); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL a_pass got=%b want=1", pass); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL a_err got=%0d want=0", err_cnt); end
        checks++; if (fail_addr !== 10'd0) begin errors++; $display("FAIL a_faddr got=%h want=0", fail_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a_busy_end got=%b want=0", busy); end
        checks++; if (cmd !== 32'hC000_0000) begin errors++; $display("FAIL a_cmd_end got=%h want=C0000000", cmd); end
    endtask

    task automatic test_stuck_at();
        int n;
        stuck_en = 1'b1;
        pulse_start();
        wait_done(n);
        checks++; if (n !== TOTAL) begin errors++; $display("FAIL b_len got=%0d want=%0d", n, TOTAL); end
        checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL b_err got=%0d want=2", err_cnt); end
        checks++; if (fail_addr !== 10'h123) begin errors++; $display("FAIL b_faddr got=%h want=123", fail_addr); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL b_pass got=%b want=0", pass); end
        stuck_en = 1'b0;
    endtask

    task automatic test_restart_force0();
        int n;
        force0_en = 1'b1;
        pulse_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL c_done_drop got=%b want=0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c_busy got=%b want=1", busy); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL c_err_clr got=%0d want=0", err_cnt); end
        checks++; if (fail_addr !== 10'd0) begin errors++; $display("FAIL c_faddr_clr got=%h want=0", fail_addr); end
        wait_done(n);
        checks++; if (n !== TOTAL) begin errors++; $display("FAIL c_len got=%0d want=%0d", n, TOTAL); end
        checks++; if (err_cnt !== 16'd1024) begin errors++; $display("FAIL c_err got=%0d want=1024", err_cnt); end
        checks++; if (fail_addr !== 10'd0) begin errors++; $display("FAIL c_faddr got=%h want=0", fail_addr); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL c_pass got=%b want=0", pass); end
        force0_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        force0_en = 1'b1;
        pulse_start();
        repeat (3 * STEP + 500) @(negedge clk);
        checks++; if (cmd !== 32'h8200_0000) begin errors++; $display("FAIL d_rff got=%h want=82000000", cmd); end
        checks++; if (err_cnt !== 16'd248) begin errors++; $display("FAIL d_err_pre got=%0d want=248", err_cnt); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd !== 32'hC000_0000) begin errors++; $display("FAIL d_cmd got=%h want=C0000000", cmd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d_busy got=%b want=0", busy); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL d_err got=%0d want=0", err_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL d_done got=%b want=0", done); end
        reset = 1'b0;
        force0_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_half_tied();
        int n;
        half_tie0 = 1'b1;
        pulse_start();
        wait_done(n);
        checks++; if (n !== TOTAL) begin errors++; $display("FAIL e_len got=%0d want=%0d", n, TOTAL); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL e_err got=%0d want=0", err_cnt); end
        checks++; if (pass !== EXP_HALF0_PASS) begin errors++; $display("FAIL e_pass got=%b want=%b", pass, EXP_HALF0_PASS); end
        half_tie0 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_clean_busy_start();
        test_stuck_at();
        test_restart_force0();
        test_reset_mid();
        test_half_tied();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_cmd_seq.md
Name: sram_cmd_seq

Overview:
Built-in self-test sequencer that sits directly upstream of the SRAM controller. It drives the controller's 32-bit command word through a fixed march-style program that writes all locations with a pattern and then reads all locations back, for patterns 00/FF/5A/A5. It checks the read-back byte stream against the expected pattern and reports pass/fail, error count and first failing address.

Parameters:
ADDR_W, 10, SRAM address width; sample count per read step = 2**ADDR_W
ALL_OP_CYCLES, 2056, cycles a write-all/read-all command is held (one full controller sweep plus margin)
GAP_CYCLES, 4, cycles NOP is held between steps so the controller passes through IDLE
RD_START_DLY, 5, cycles from read-step start to first outp_data sample
ERR_W, 16, width of error counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  single-cycle pulse, launches the program
cmd  out  32  command word to controller: [31:30] op (11 wr-all, 10 rd-all), [27:24] one-hot pattern, [23:16] data, [15:0] addr
outp_data  in  8  read data returned by controller
half  in  1  controller half-sweep flag
busy  out  1  program running
done  out  1  program finished; held until next start/reset
pass  out  1  valid when done: 1 if err_cnt==0 (and no protocol error when SEQ_HALF_CHECK_EN)
err_cnt  out  ERR_W  mismatching samples, saturating
fail_addr  out  ADDR_W  sample index of first mismatch; 0 if none

Behaviour:
- Reset (sync, active-high, clk rising edge): state S_IDLE; cmd=NOP=32'hC000_0000 (write-all, pattern 0000: controller loops to IDLE, writes nothing); busy=0, done=0, pass=0, err_cnt=0, fail_addr=0; step, timer, sample counters=0. Reset mid-program aborts immediately; outputs return to these values on the next edge.
- Program ROM, 8 steps, index 0..7: W00, R00, WFF, RFF, W5A, R5A, WA5, RA5. Wxx cmd = {2'b11,2'b00,pat,8'h00,16'h0000}; Rxx cmd = {2'b10,2'b00,pat,8'h00,16'h0000}; pat one-hot 0001=00, 0010=FF, 0100=5A, 1000=A5.
- FSM:
  S_IDLE: on start -> S_ISSUE, step=0, timer=0, err_cnt/fail_addr/pass/done cleared, busy=1 on next cycle.
  S_ISSUE: cmd=ROM[step]; timer increments each cycle; at timer==ALL_OP_CYCLES-1 -> S_GAP, timer=0.
  S_GAP: cmd=NOP; at timer==GAP_CYCLES-1: if step==7 -> S_DONE, else step+1 -> S_ISSUE.
  S_DONE: busy=0, done=1, pass valid, cmd=NOP; start -> behaves as from S_IDLE (restart, clears results).
- start while busy: ignored.
- Read checking (read steps only, in S_ISSUE): sample outp_data when timer>=RD_START_DLY, (timer-RD_START_DLY) even, and sample index<2**ADDR_W. Each sample compared to the step's pattern byte. On mismatch: err_cnt+1, saturating at all-ones; if first mismatch of program, fail_addr=sample index. Sample index resets to 0 at each step start.
- Timer is 12 bits; ALL_OP_CYCLES must exceed RD_START_DLY+2*2**ADDR_W; violation is a configuration error, no runtime check.
- pass registered on entry to S_DONE.

Optional Feature:
SEQ_HALF_CHECK_EN: when defined, per-step flag records whether half was seen high during S_ISSUE; if a step ends without it, sticky proto_err is set and forces pass=0. proto_err is cleared on start and on reset. Not defined: half ignored, no extra logic.

Decomposition:
- Package sram_test_pkg: op codes (OP_WR_ALL, OP_RD_ALL, OP_WR_ONE, OP_RD_ONE), pattern one-hot codes and byte values, NOP word, FSM state constants.
- One sub-module: sram_rd_checker, covering sample strobe generation, compare, err_cnt saturation and fail_addr capture. The top FSM supplies step start, expected byte and read-step enable.

Test Plan:
- Bench model of controller plus a fault-free 1Kx8 SRAM; pulse start -> 8 steps each ALL_OP_CYCLES+GAP_CYCLES long; done=1, pass=1, err_cnt=0, fail_addr=0.
- Stuck-at-0 on bit 7 of address 0x123 -> FF and A5 reads mismatch there -> err_cnt=2, fail_addr=0x123, pass=0.
- Read data forced to 0x00 during RFF step -> err_cnt=1024, fail_addr=0.
- reset asserted at step 3, timer 500 -> next cycle cmd=32'hC000_0000, busy=0, err_cnt=0. Then start -> full clean run, pass=1.
- start pulses during busy at steps 1 and 6 -> no restart, step sequence and timing unchanged. start in S_DONE -> restart, done drops next cycle.
- With SEQ_HALF_CHECK_EN, half tied 0 in the bench -> run completes, err_cnt=0, pass=0. Without the macro, same stimulus -> pass=1.
